// File: rtl/mash_pkg.sv
// mash_pkg: shared constants for the MASH delta-sigma modulator.
//   MAX_ORDER   - number of cascaded first-order stages
//   LFSR_*      - dither LFSR width, feedback taps and reload seed
//   ord_e       - encodings of the ord_i order-select input
//   lfsr_next() - one Fibonacci step of the dither LFSR
package mash_pkg;

    localparam int MAX_ORDER = 3;

    localparam int                LFSR_W    = 15;
    // x^15 + x^14 + 1: feedback is the XOR of bits 14 and 13.
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 15'h6000;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 15'h0001;

    typedef enum logic [1:0] {
        ORD_BYPASS  = 2'd0,
        ORD_MASH1   = 2'd1,
        ORD_MASH11  = 2'd2,
        ORD_MASH111 = 2'd3
    } ord_e;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/efm_stage.sv
// efm_stage: one error-feedback first-order modulator stage.
//   clk, rst    - clock, asynchronous active-high reset
//   en          - advance the accumulator this cycle
//   clr         - synchronous clear of the accumulator
//   force_zero  - stage is outside the selected order; hold accumulator at 0
//   in_word     - stage input (x_eff for stage 1, previous stage error otherwise)
//   carry       - combinational overflow of in_word + acc
//   err         - combinational low WIDTH bits of in_word + acc
module efm_stage
    import mash_pkg::*;
#(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             force_zero,
    input  logic [WIDTH-1:0] in_word,
    output logic             carry,
    output logic [WIDTH-1:0] err
);

    logic [WIDTH-1:0] acc_q;
    logic [WIDTH:0]   sum;

    assign sum   = {1'b0, in_word} + {1'b0, acc_q};
    assign carry = sum[WIDTH];
    assign err   = sum[WIDTH-1:0];

    // Clear and force-zero act every cycle, independent of en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else if (clr || force_zero) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= err;
        end
    end

endmodule

// File: rtl/mash_dsm.sv
// mash_dsm: MASH 1 / 1-1 / 1-1-1 delta-sigma modulator with optional LFSR dither.
//   clk, rst     - clock, asynchronous active-high reset
//   en_i         - advance enable; all state holds when low
//   clr_i        - synchronous clear of all state (overrides en_i)
//   ord_i        - 0 bypass, 1/2/3 = MASH 1, 1-1, 1-1-1
//   dither_en_i  - add the LFSR output bit to the stage-1 input
//   x_i          - unsigned fractional word, mean(y_o) = x_i / 2^WIDTH
//   y_o          - registered signed correction word
//   vld_o        - registered copy of en_i (low on clearing cycles)
// Output timing: vld_o is high exactly in the cycle after an enabled,
// non-clearing cycle, and y_o then carries that cycle's result. There is
// no ready; the output cannot be back-pressured.
module mash_dsm
    import mash_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int OUT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [1:0]       ord_i,
    input  logic             dither_en_i,
    input  logic [WIDTH-1:0] x_i,
    output logic [OUT_W-1:0] y_o,
    output logic             vld_o
);

    ord_e ord;
    assign ord = ord_e'(ord_i);

    logic [LFSR_W-1:0] lfsr_q;
    logic              dith_bit;
    logic [WIDTH-1:0]  x_eff;

    // Wraps modulo 2^WIDTH: all-ones plus a dither bit gives 0.
    assign dith_bit = dither_en_i & lfsr_q[0];
    assign x_eff    = x_i + {{(WIDTH-1){1'b0}}, dith_bit};

    logic             c1, c2, c3;
    logic [WIDTH-1:0] e1, e2;
    logic [WIDTH-1:0] e3_unused;  // last stage error feeds no further stage

    efm_stage #(.WIDTH(WIDTH)) u_stage1 (
        .clk(clk), .rst(rst), .en(en_i), .clr(clr_i),
        .force_zero(ord == ORD_BYPASS),
        .in_word(x_eff), .carry(c1), .err(e1)
    );

    efm_stage #(.WIDTH(WIDTH)) u_stage2 (
        .clk(clk), .rst(rst), .en(en_i), .clr(clr_i),
        .force_zero(ord < ORD_MASH11),
        .in_word(e1), .carry(c2), .err(e2)
    );

    efm_stage #(.WIDTH(WIDTH)) u_stage3 (
        .clk(clk), .rst(rst), .en(en_i), .clr(clr_i),
        .force_zero(ord < ORD_MASH111),
        .in_word(e2), .carry(c3), .err(e3_unused)
    );

    // Noise cancellation: differentiate carries of the later stages.
    logic c2_d, c3_d, c3_dd;
    logic signed [OUT_W-1:0] t1, t2, t2d, t3, t3d, t3dd, y_next;

    assign t1   = {{(OUT_W-1){1'b0}}, c1};
    assign t2   = {{(OUT_W-1){1'b0}}, c2};
    assign t2d  = {{(OUT_W-1){1'b0}}, c2_d};
    assign t3   = {{(OUT_W-1){1'b0}}, c3};
    assign t3d  = {{(OUT_W-1){1'b0}}, c3_d};
    assign t3dd = {{(OUT_W-1){1'b0}}, c3_dd};

    // Order-3 range is -3..+4, which fits OUT_W >= 4 without overflow.
    always_comb begin
        y_next = '0;
        case (ord)
            ORD_MASH1:   y_next = t1;
            ORD_MASH11:  y_next = t1 + t2 - t2d;
            ORD_MASH111: y_next = t1 + t2 - t2d + t3 - (t3d <<< 1) + t3dd;
            default:     y_next = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
            c2_d   <= 1'b0;
            c3_d   <= 1'b0;
            c3_dd  <= 1'b0;
            y_o    <= '0;
            vld_o  <= 1'b0;
        end else begin
            vld_o <= en_i & ~clr_i;
            if (clr_i) begin
                lfsr_q <= LFSR_SEED;
                c2_d   <= 1'b0;
                c3_d   <= 1'b0;
                c3_dd  <= 1'b0;
                y_o    <= '0;
            end else begin
                if (en_i) begin
                    lfsr_q <= lfsr_next(lfsr_q);
                    c2_d   <= c2;
                    c3_d   <= c3;
                    c3_dd  <= c3_d;
                    y_o    <= y_next;
                end
                // Unused stages are flushed every cycle; later assignments win.
                if (ord < ORD_MASH11) begin
                    c2_d <= 1'b0;
                end
                if (ord < ORD_MASH111) begin
                    c3_d  <= 1'b0;
                    c3_dd <= 1'b0;
                end
                if (ord == ORD_BYPASS) begin
                    y_o <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mash_dsm.sv
// tb_mash_dsm: self-checking bench for mash_dsm (WIDTH = 24, OUT_W = 4).
module tb_mash_dsm;

    localparam int W  = 24;
    localparam int OW = 4;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst;
    logic          en_i, clr_i, dither_en_i;
    logic [1:0]    ord_i;
    logic [W-1:0]  x_i;
    logic [OW-1:0] y_o;
    logic          vld_o;

    always #5 clk = ~clk;

    mash_dsm #(.WIDTH(W), .OUT_W(OW)) dut (
        .clk(clk), .rst(rst), .en_i(en_i), .clr_i(clr_i), .ord_i(ord_i),
        .dither_en_i(dither_en_i), .x_i(x_i), .y_o(y_o), .vld_o(vld_o)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [OW:0] exp_q[$];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // Stages are plain integer accumulators modulo 2^W; carries are the
    // integer quotient of the sum by 2^W.
    longint m_acc[1:3];
    int     m_c2d, m_c3d, m_c3dd, m_y, m_lfsr;
    bit     m_vld;

    function automatic void model_reset();
        for (int k = 1; k <= 3; k++) m_acc[k] = 0;
        m_c2d = 0; m_c3d = 0; m_c3dd = 0; m_y = 0; m_lfsr = 1; m_vld = 0;
    endfunction

    function automatic void model_step(bit en, bit clr, int ord, bit dith, longint x);
        longint modw = longint'(1) << W;
        longint in_w, s;
        longint e[1:3];
        int     c[1:3];
        int     ynew, nb;
        if (clr) begin
            model_reset();
            return;
        end
        m_vld = en;
        in_w  = (x + (dith ? (m_lfsr & 1) : 0)) % modw;
        for (int k = 1; k <= 3; k++) begin
            s    = in_w + m_acc[k];
            c[k] = int'(s / modw);
            e[k] = s % modw;
            in_w = e[k];
        end
        case (ord)
            1:       ynew = c[1];
            2:       ynew = c[1] + c[2] - m_c2d;
            3:       ynew = c[1] + c[2] - m_c2d + c[3] - 2 * m_c3d + m_c3dd;
            default: ynew = 0;
        endcase
        if (en) begin
            for (int k = 1; k <= 3; k++) m_acc[k] = e[k];
            m_c3dd = m_c3d; m_c3d = c[3]; m_c2d = c[2];
            nb     = ((m_lfsr >> 14) ^ (m_lfsr >> 13)) & 1;
            m_lfsr = ((m_lfsr << 1) | nb) & 32'h7fff;
            m_y    = ynew;
        end
        for (int k = 1; k <= 3; k++) if (k > ord) m_acc[k] = 0;
        if (ord < 2) m_c2d = 0;
        if (ord < 3) begin m_c3d = 0; m_c3dd = 0; end
        if (ord == 0) m_y = 0;
    endfunction

    // ---------------- driver ----------------
    task automatic step(input bit en, input bit clr, input logic [1:0] ord,
                        input bit dith, input logic [W-1:0] x);
        logic [OW:0]   exp;
        logic [OW-1:0] yb;
        en_i = en; clr_i = clr; ord_i = ord; dither_en_i = dith; x_i = x;
        model_step(en, clr, int'(ord), dith, longint'(x));
        yb = m_y[OW-1:0];
        exp_q.push_back({m_vld, yb});
        @(posedge clk);
        #1;
        exp = exp_q.pop_front();
        check("step_vld_y", longint'({vld_o, y_o}), longint'(exp));
    endtask

    task automatic check_zero_state(input string name);
        check({name, "_acc1"}, longint'(dut.u_stage1.acc_q), 0);
        check({name, "_acc2"}, longint'(dut.u_stage2.acc_q), 0);
        check({name, "_acc3"}, longint'(dut.u_stage3.acc_q), 0);
        check({name, "_dly"}, longint'({dut.c2_d, dut.c3_d, dut.c3_dd}), 0);
        check({name, "_lfsr"}, longint'(dut.lfsr_q), 1);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit            en;
        bit            clr;
        bit            dith;
        logic [1:0]    ord;
        logic [W-1:0]  x;
        logic [OW-1:0] ey;
        bit            ev;
    } vec_t;

    function automatic vec_t mk(bit en, bit clr, bit dith, logic [1:0] ord,
                                logic [W-1:0] x, logic [OW-1:0] ey, bit ev);
        vec_t v;
        v.en = en; v.clr = clr; v.dith = dith; v.ord = ord; v.x = x; v.ey = ey; v.ev = ev;
        return v;
    endfunction

    vec_t tbl[22];

    initial begin
        logic [OW-1:0] g[60];
        logic [OW-1:0] y_hold;
        int            sum, bad, n;
        logic [1:0]    r_ord;
        bit            r_dith;

        // ---- reset with arbitrary inputs ----
        rst = 1'b1; en_i = 1'b1; clr_i = 1'b0; ord_i = 2'd3; dither_en_i = 1'b1;
        x_i = W'($urandom);
        repeat (3) @(posedge clk);
        #1;
        check("reset_y", longint'(y_o), 0);
        check("reset_vld", longint'(vld_o), 0);
        check_zero_state("reset");
        rst = 1'b0;
        model_reset();

        // ---- table: MASH1 half-scale, hold, clear, bypass, MASH1-1, wrap ----
        tbl[0]  = mk(1, 0, 0, 2'd1, 24'h800000, 4'd0, 1);
        tbl[1]  = mk(1, 0, 0, 2'd1, 24'h800000, 4'd1, 1);
        tbl[2]  = mk(1, 0, 0, 2'd1, 24'h800000, 4'd0, 1);
        tbl[3]  = mk(1, 0, 0, 2'd1, 24'h800000, 4'd1, 1);
        tbl[4]  = mk(0, 0, 0, 2'd1, 24'h800000, 4'd1, 0);
        tbl[5]  = mk(1, 0, 0, 2'd1, 24'h800000, 4'd0, 1);
        tbl[6]  = mk(1, 1, 0, 2'd1, 24'h800000, 4'd0, 0);
        tbl[7]  = mk(1, 0, 0, 2'd1, 24'h800000, 4'd0, 1);
        tbl[8]  = mk(1, 0, 0, 2'd1, 24'h800000, 4'd1, 1);
        tbl[9]  = mk(1, 0, 0, 2'd0, 24'h800000, 4'd0, 1);
        tbl[10] = mk(1, 0, 0, 2'd1, 24'h800000, 4'd0, 1);
        tbl[11] = mk(1, 0, 0, 2'd1, 24'h800000, 4'd1, 1);
        tbl[12] = mk(1, 1, 0, 2'd2, 24'hC00000, 4'd0, 0);
        tbl[13] = mk(1, 0, 0, 2'd2, 24'hC00000, 4'd0, 1);
        tbl[14] = mk(1, 0, 0, 2'd2, 24'hC00000, 4'd2, 1);
        tbl[15] = mk(1, 0, 0, 2'd2, 24'hC00000, 4'd0, 1);
        tbl[16] = mk(1, 0, 0, 2'd2, 24'hC00000, 4'd1, 1);
        tbl[17] = mk(1, 0, 0, 2'd2, 24'hC00000, 4'd1, 1);
        tbl[18] = mk(1, 1, 1, 2'd1, 24'hFFFFFF, 4'd0, 0);
        tbl[19] = mk(1, 0, 1, 2'd1, 24'hFFFFFF, 4'd0, 1);
        tbl[20] = mk(1, 0, 1, 2'd1, 24'hFFFFFF, 4'd0, 1);
        tbl[21] = mk(1, 0, 1, 2'd1, 24'hFFFFFF, 4'd1, 1);
        for (int i = 0; i < 22; i++) begin
            step(tbl[i].en, tbl[i].clr, tbl[i].ord, tbl[i].dith, tbl[i].x);
            check($sformatf("tbl%0d_y", i), longint'(y_o), longint'(tbl[i].ey));
            check($sformatf("tbl%0d_vld", i), longint'(vld_o), longint'(tbl[i].ev));
        end

        // ---- clear with enable matches post-reset; order 3 -> 1 flushes ----
        for (int i = 0; i < 20; i++) step(1, 0, 2'd3, 1, W'($urandom));
        step(1, 1, 2'd3, 1, W'($urandom));
        check("clr_y", longint'(y_o), 0);
        check_zero_state("clr");
        for (int i = 0; i < 20; i++) step(1, 0, 2'd3, 0, W'($urandom));
        step(1, 0, 2'd1, 0, W'($urandom));
        check("ord31_acc2", longint'(dut.u_stage2.acc_q), 0);
        check("ord31_acc3", longint'(dut.u_stage3.acc_q), 0);
        check("ord31_dly", longint'({dut.c2_d, dut.c3_d, dut.c3_dd}), 0);

        // ---- enable hold matches the uninterrupted sequence ----
        step(1, 1, 2'd3, 1, 24'h123457);
        for (int i = 0; i < 60; i++) begin
            step(1, 0, 2'd3, 1, 24'h123457);
            g[i] = y_o;
        end
        step(1, 1, 2'd3, 1, 24'h123457);
        for (int i = 0; i < 30; i++) begin
            step(1, 0, 2'd3, 1, 24'h123457);
            check("gold_pre", longint'(y_o), longint'(g[i]));
        end
        y_hold = y_o;
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 2'd3, 1, W'($urandom));
            check("hold_y", longint'(y_o), longint'(y_hold));
            check("hold_vld", longint'(vld_o), 0);
        end
        for (int i = 30; i < 60; i++) begin
            step(1, 0, 2'd3, 1, 24'h123457);
            check("gold_post", longint'(y_o), longint'(g[i]));
        end

        // ---- MASH 1-1-1 quarter scale: range and mean ----
        step(1, 1, 2'd3, 0, 24'h400000);
        sum = 0; bad = 0;
        for (int i = 0; i < 4096; i++) begin
            step(1, 0, 2'd3, 0, 24'h400000);
            sum += int'($signed(y_o));
            if ($signed(y_o) < -3 || $signed(y_o) > 4) bad++;
        end
        check("ord3_range", bad, 0);
        check("ord3_sum", (sum >= 1021 && sum <= 1027) ? 1 : 0, 1);

        // ---- zero input: exact zeros, then dithered mean ----
        step(1, 1, 2'd3, 0, '0);
        bad = 0;
        for (int i = 0; i < 500; i++) begin
            step(1, 0, 2'd3, 0, '0);
            if (y_o != '0) bad++;
        end
        check("zero_in", bad, 0);
        sum = 0; n = 2000;
        for (int i = 0; i < n; i++) begin
            step(1, 0, 2'd3, 1, '0);
            sum += int'($signed(y_o));
        end
        check("dither_mean", (longint'(sum < 0 ? -sum : sum) * (longint'(1) << 20) <= n) ? 1 : 0, 1);

        // ---- randomized run against the model, with a mid-run reset ----
        r_ord = 2'd3; r_dith = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 3) r_ord = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) < 2) r_dith = ~r_dith;
            step($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 2,
                 r_ord, r_dith, W'($urandom));
            if (i == 1500) begin
                #2 rst = 1'b1;
                #1;
                check("async_rst_y", longint'(y_o), 0);
                check("async_rst_vld", longint'(vld_o), 0);
                check_zero_state("async_rst");
                model_reset();
                @(posedge clk);
                #1 rst = 1'b0;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mash_dsm.md
MASH_DSM -- requirements
Module: mash_dsm

Interface
REQ-001 Parameter WIDTH, default 24: accumulator and input word width, legal range 8..32.
REQ-002 Parameter OUT_W, default 4: signed output width, SHALL be >= 4.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 en_i  input  1  advance enable; when low, all state holds.
REQ-006 clr_i  input  1  synchronous clear of all modulator state.
REQ-007 ord_i  input  2  order select: 0 = bypass, 1/2/3 = MASH 1, 1-1 or 1-1-1.
REQ-008 dither_en_i  input  1  adds an LFSR bit to the stage-1 input.
REQ-009 x_i  input  WIDTH  unsigned fractional word; mean output = x_i / 2^WIDTH.
REQ-010 y_o  output  OUT_W  signed two's-complement correction, registered.
REQ-011 vld_o  output  1  registered copy of en_i; marks cycles where y_o was updated.

Function
REQ-012 Stage k SHALL hold accumulator acc_k (WIDTH bits) and form sum_k = in_k + acc_k (WIDTH+1 bits); carry c_k = sum_k[WIDTH]; error e_k = sum_k[WIDTH-1:0].
REQ-013 Stage-1 input SHALL be x_eff = (x_i + d) mod 2^WIDTH, where d = LFSR bit when dither_en_i = 1 and 0 otherwise; x_i = all-ones with d = 1 wraps to 0.
REQ-014 Stage k input for k >= 2 SHALL be the combinational e_(k-1) of the same cycle; on an enabled cycle acc_k <= e_k.
REQ-015 Noise cancellation SHALL use delay registers c2_d, c3_d and c3_dd, updated only on enabled cycles.
REQ-016 Order 1: y = c1.
REQ-017 Order 2: y = c1 + c2 - c2_d.
REQ-018 Order 3: y = c1 + c2 - c2_d + c3 - 2*c3_d + c3_dd.
REQ-019 The order-3 range SHALL be -3..+4; the sum SHALL be computed at OUT_W bits signed without overflow.
REQ-020 y_o <= y on every cycle with en_i = 1 and clr_i = 0; latency is one cycle from x_i to y_o.
REQ-021 en_i = 0: acc_k, the delay registers, the LFSR and y_o SHALL hold; vld_o <= 0.
REQ-022 clr_i = 1 SHALL override en_i: all acc_k, delay registers and y_o <= 0, the LFSR reloads its seed, and vld_o <= 0.
REQ-023 Stages with index > ord_i SHALL have their accumulator and delay registers forced to 0 every cycle; an ord_i change takes effect on the next enabled cycle with no other flush.
REQ-024 ord_i = 0 SHALL force all state to 0 and y_o to 0; vld_o still follows en_i.
REQ-025 The LFSR SHALL be 15-bit Fibonacci, x^15 + x^14 + 1, seed 15'h0001, output bit [0], advancing only on enabled cycles.

Reset
REQ-026 rst high SHALL asynchronously set all acc_k, c2_d, c3_d, c3_dd, y_o and vld_o to 0 and the LFSR to 15'h0001.
REQ-027 Reset deassertion mid-operation SHALL resume from the all-zero state on the first enabled cycle; no partial state is retained.

Structure
REQ-028 Shared package mash_pkg SHALL hold MAX_ORDER = 3, the LFSR width, polynomial taps and seed, and the order-select encodings.
REQ-029 One sub-module, efm_stage (accumulator, carry and error, with enable and force-zero inputs), SHALL be instantiated three times.
REQ-030 The noise-cancellation network and the LFSR SHALL live in the top level.

Verification
REQ-031 Reset: rst = 1 with any inputs -> y_o = 0, vld_o = 0 and all internal state 0 while rst is held.
REQ-032 ord_i = 1, x_i = 24'h800000, dither off, en_i = 1 -> y_o sequence 0, 1, 0, 1, ... from the first enabled cycle.
REQ-033 ord_i = 3, x_i = 24'h400000, dither off, 4096 enabled cycles -> every y_o in -3..+4 and the sum of y_o = 1024 +/- 3.
REQ-034 ord_i = 3, x_i = 0, dither off -> y_o = 0 on all cycles; with dither on -> the long-run mean of y_o is within 2^-20 of 0.
REQ-035 Mid-run, hold en_i = 0 for 10 cycles -> y_o frozen and vld_o = 0; the resumed sequence equals the uninterrupted golden sequence.
REQ-036 clr_i = 1 and en_i = 1 in the same cycle -> next y_o = 0 and the state matches post-reset; ord_i 3 -> 1 mid-run -> stage-2/3 state reads 0 one cycle later.
